// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
// Shared definitions for the data-memory responder: the FSM state encoding,
// the memory word width and the latency limits.
package mem_resp_pkg;

   localparam int WORD_W      = 32;
   localparam int MAX_LATENCY = 15;
   // Wide enough to hold MAX_LATENCY-1.
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array
// Word storage for the responder: single port, synchronous write,
// combinational read. Contents are not reset.
// Ports:
//   clk      - clock, write on rising edge
//   i_we     - write enable
//   i_addr   - word index (shared by read and write)
//   i_wdata  - write data
//   o_rdata  - combinational read data at i_addr
module mem_array
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Fixed-latency data-memory responder for a CPU load/store port. One access
// is in flight at a time; stores commit on acceptance, loads sample the
// array when the latency counter expires. Misaligned or out-of-range
// accesses return rsp_err=1 with zero data and never touch the array.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   req_valid/req_ready     - request handshake (ready only in IDLE)
//   req_we                  - 1 = store, 0 = load
//   req_addr, req_wdata     - byte address, store data
//   rsp_valid/rsp_ready     - response handshake (valid only in RESP)
//   rsp_rdata, rsp_err      - registered response data and error flag
//
// state | meaning
// IDLE  | ready to accept a request
// BUSY  | request accepted, counting down the latency
// RESP  | response presented, waiting for rsp_ready
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2    // legal range 1..MAX_LATENCY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_idx;
   logic                r_we;
   logic                r_err;
   logic [WORD_W-1:0]   r_rsp_rdata;
   logic                r_rsp_err;

   logic                w_accept;
   logic                w_misaligned;
   logic                w_out_of_range;
   logic                w_err_in;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_idx;
   logic [WORD_W-1:0]   w_mem_rdata;
   logic                w_cnt_done;

   assign w_misaligned   = (req_addr[1:0] != 2'b00);
   assign w_out_of_range = ((req_addr >> (ADDR_W + 2)) != 32'd0);
   assign w_err_in       = w_misaligned || w_out_of_range;
   assign w_accept       = req_valid && (r_state == IDLE);
   assign w_cnt_done     = (r_cnt == '0);

   // Store data is written straight through on the acceptance edge, so only
   // the word index, direction and error flag are held for the response.
   assign w_mem_we  = w_accept && req_we && !w_err_in;
   // Single port: IDLE addresses the incoming request, otherwise the held one.
   assign w_mem_idx = (r_state == IDLE) ? req_addr[ADDR_W+1:2] : r_idx;

   mem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_addr  (w_mem_idx),
      .i_wdata (req_wdata),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (w_cnt_done) begin
               w_state_nxt = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         r_idx       <= '0;
         r_we        <= 1'b0;
         r_err       <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= CNT_LOAD;
         r_idx <= req_addr[ADDR_W+1:2];
         r_we  <= req_we;
         r_err <= w_err_in;
      end else if (r_state == BUSY) begin
         if (w_cnt_done) begin
            r_rsp_rdata <= (r_we || r_err) ? '0 : w_mem_rdata;
            r_rsp_err   <= r_err;
         end else begin
            r_cnt <= r_cnt - CNT_ONE;
         end
      end
   end

   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 8, meaning the word-address width, so depth is 2^ADDR_W 32-bit words.
REQ-002 The block SHALL take parameter LATENCY, default 2, meaning the cycles from request acceptance to response; the legal range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the CPU presents a data-memory request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 means store (MW), 0 means load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: the store data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: the CPU consumes the response.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: load data; it is 0 for stores and for errors.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the access was misaligned or out of range.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, BUSY and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 rsp_valid SHALL be 1 only in RESP.
REQ-017 A request SHALL be accepted on the edge where req_valid && req_ready.
REQ-018 On acceptance, the block SHALL register addr, we and wdata, load cnt = LATENCY-1 and move to BUSY.
REQ-019 In BUSY, on each edge: if cnt == 0 the block SHALL move to RESP, otherwise it SHALL decrement cnt.
REQ-020 Consequence of REQ-018/REQ-019: rsp_valid SHALL first be high in the cycle after the LATENCY-th edge following acceptance.
REQ-021 A store SHALL commit to the array on its acceptance edge.
REQ-022 A load SHALL sample the array on the BUSY->RESP edge into a response register.
REQ-023 rsp_rdata and rsp_err SHALL be registered and SHALL hold stable throughout RESP.
REQ-024 In RESP, the block SHALL move to IDLE on an edge with rsp_ready=1; while rsp_ready=0 it SHALL stay in RESP indefinitely.
REQ-025 There SHALL be no IDLE bypass: a new request is accepted no earlier than one cycle after the response handshake, so peak throughput is one access per LATENCY+2 cycles.
REQ-026 An access SHALL be misaligned when req_addr[1:0] != 0.
REQ-027 An access SHALL be out of range when req_addr[31:ADDR_W+2] != 0.
REQ-028 On an error access, the block SHALL set rsp_err=1 and rsp_rdata=0, SHALL NOT write the array, and SHALL use the same latency as a good access.
REQ-029 The word index SHALL be req_addr[ADDR_W+1:2].
REQ-030 The highest word (index 2^ADDR_W - 1) SHALL be legal; the next word SHALL be an error.
REQ-031 req_valid asserted while the block is in BUSY or RESP SHALL be ignored and SHALL have no side effects.
REQ-032 Simultaneous rsp_ready and req_valid in RESP: the response completes, and the request is not accepted until the following IDLE cycle.
REQ-033 A store response SHALL carry rsp_rdata=0 and SHALL carry rsp_err according to the error checks.

Reset
REQ-034 Reset SHALL force state=IDLE, cnt=0, rsp_rdata=0, rsp_err=0 and all registered request fields to 0; consequently req_ready=1 and rsp_valid=0 while reset is high.
REQ-035 Reset asserted mid-operation SHALL abort the outstanding response.
REQ-036 A store already accepted before reset SHALL remain committed.
REQ-037 Array contents SHALL NOT be reset; a load from a never-written word returns an unspecified value.

Structure
REQ-038 Package mem_resp_pkg SHALL hold the state enum (IDLE/BUSY/RESP), the word width 32, and the maximum LATENCY constant 15.
REQ-039 Sub-module mem_array SHALL hold the storage: single port, synchronous write, combinational read, parameterised by ADDR_W.
REQ-040 The FSM, counter, error check and response registers SHALL live in mem_responder.

Verification
REQ-041 Bench SHALL cover store then load: store 0xDEADBEEF to 0x10, then load 0x10 with LATENCY=2 -> each rsp_valid rises exactly 2 edges after acceptance; load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-042 Bench SHALL cover misalignment: load from 0x13 -> rsp_err=1, rsp_rdata=0; a subsequent load of 0x10 still returns 0xDEADBEEF.
REQ-043 Bench SHALL cover range, ADDR_W=8: store 0x12345678 to 0x3FC -> rsp_err=0 and read-back matches; store to 0x400 -> rsp_err=1 and no array change.
REQ-044 Bench SHALL cover backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 throughout -> rsp_valid and data stay stable, req_ready=0, and no second acceptance occurs until one cycle after rsp_ready=1.
REQ-045 Bench SHALL cover reset in BUSY: accept a load, assert reset at cnt=0 -> rsp_valid=0, req_ready=1 immediately; after release the next request completes normally.
REQ-046 Bench SHALL cover LATENCY=1 and LATENCY=15: rsp_valid appears exactly 1 and 15 edges after acceptance respectively.
